snn_step_sequencer: RTL and testbench

Timestep controller for one neuron block. It runs a programmed number of SNN timesteps and keeps the T-deep spike history that feeds back into the block's inputs. Per step it grants at most one force-spike request from R requesters (round-robin) and drives the block's force-spike select/enable. It captures the block's spike output once per step and publishes it. It sits between the host/test controller and the neuron block.

---
 rtl/snn_step_sequencer_pkg.sv | 27 ++
 rtl/snn_step_sequencer_if.sv | 24 ++
 rtl/snn_step_sequencer_rr_arbiter.sv | 40 ++++
 rtl/snn_step_sequencer.sv | 172 +++++++++++++++++
 tb/tb_snn_step_sequencer.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_step_sequencer_pkg.sv
// Shared types and helpers for the SNN timestep sequencer.
// Holds the step FSM encoding and the round-robin pick function.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INJECT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } step_state_t;

    // First set bit of req at or after ptr+1, wrapping; -1 if none.
    function automatic int rr_pick(
        input logic [31:0] req,
        input int          ptr,
        input int          n
    );
        int idx;
        rr_pick = -1;
        for (int k = n; k >= 1; k--) begin
            idx = (ptr + k) % n;
            if (req[idx[4:0]]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/snn_step_sequencer_if.sv
// Force-spike request bus between requesters and the sequencer.
// Requests are levels held until a one-cycle grant returns.
interface snn_step_sequencer_if #(
    parameter int R = 2,
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [R-1:0]         force_req;
    logic [R-1:0][IW-1:0] force_idx;
    logic [R-1:0]         force_gnt;

    modport master (
        output force_req,
        output force_idx,
        input  force_gnt
    );

    modport slave (
        input  force_req,
        input  force_idx,
        output force_gnt
    );
endinterface

// File: rtl/snn_step_sequencer_rr_arbiter.sv
// Round-robin arbiter with a pointer that moves only on enabled grants.
// Grant is combinational; the caller registers it if needed.
module rr_arbiter
    import snn_pkg::*;
#(
    parameter  int R  = 2,
    localparam int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [R-1:0]  req,
    output logic [R-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          req_any
);
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            pick;

    // Pick the next requester after the pointer and advance on use.
    always_comb begin
        pick    = rr_pick(32'(req), int'(ptr_q), R);
        req_any = (pick >= 0);
        gnt     = '0;
        gnt_idx = '0;
        ptr_d   = ptr_q;
        if (req_any) begin
            gnt_idx      = PW'(pick);
            gnt[gnt_idx] = 1'b1;
            if (en) ptr_d = gnt_idx;
        end
    end

    // Pointer starts at the last index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset) ptr_q <= PW'(R - 1);
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/snn_step_sequencer.sv
// Timestep controller for one neuron block: force injection,
// settle, spike capture and T-deep history feedback per step.
module snn_step_sequencer
    import snn_pkg::*;
#(
    parameter  int T      = 4,
    parameter  int N      = 8,
    parameter  int R      = 2,
    parameter  int SETTLE = 2,
    parameter  int SW     = 16,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SW-1:0]        num_steps,
    output logic                 busy,
    output logic                 done,
    output logic [SW-1:0]        step_count,
    snn_step_sequencer_if.slave  frc,
    output logic [T-1:0][N-1:0]  spike_hist,
    input  logic [N-1:0]         blk_spike,
    output logic [IW-1:0]        force_spike_neuron_select,
    output logic                 force_spike_en,
    output logic                 spike_valid,
    output logic [N-1:0]         spike_data
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = $clog2(SETTLE + 1);

    step_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       num_q, num_d;
    logic [SW-1:0]       step_q, step_d;
    logic [T-1:0][N-1:0] hist_q, hist_d;
    logic [N-1:0]        data_q, data_d;
    logic [R-1:0]        gnt_q, gnt_d;
    logic [IW-1:0]       sel_q, sel_d;
    logic                en_q, en_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                arb_en;
    logic [R-1:0]        arb_gnt;
    logic [PW-1:0]       arb_idx;
    logic                arb_any;
    logic [IW-1:0]       tgt;
    logic [SW-1:0]       step_inc;

    rr_arbiter #(.R(R)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .req     (frc.force_req),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .req_any (arb_any)
    );

    assign tgt = frc.force_idx[arb_idx];

    // Step FSM next state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        step_d   = step_q;
        hist_d   = hist_q;
        data_d   = data_q;
        sel_d    = sel_q;
        en_d     = en_q;
        gnt_d    = '0;
        valid_d  = 1'b0;
        arb_en   = 1'b0;
        step_inc = step_q + SW'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (num_steps != '0) begin
                        num_d   = num_steps;
                        step_d  = '0;
                        hist_d  = '0;
                        state_d = ST_INJECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_INJECT: begin
                arb_en  = 1'b1;
                en_d    = 1'b0;
                if (arb_any) begin
                    gnt_d = arb_gnt;
                    sel_d = tgt;
                    en_d  = (32'(tgt) < N);
                end
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CW'(SETTLE - 1)) state_d = ST_CAPTURE;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            ST_CAPTURE: begin
                hist_d[0] = blk_spike;
                for (int k = 1; k < T; k++) hist_d[k] = hist_q[k-1];
                data_d  = blk_spike;
                valid_d = 1'b1;
                step_d  = step_inc;
                en_d    = 1'b0;
                state_d = (step_inc == num_q) ? ST_DONE : ST_INJECT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            gnt_d   = '0;
            valid_d = 1'b0;
            arb_en  = 1'b0;
            hist_d  = hist_q;
            step_d  = step_q;
            data_d  = data_q;
            sel_d   = sel_q;
        end
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared while reset is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            step_q  <= '0;
            hist_q  <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            step_q  <= step_d;
            hist_q  <= hist_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy                      = busy_q;
    assign done                      = done_q;
    assign step_count                = step_q;
    assign frc.force_gnt             = gnt_q;
    assign spike_hist                = hist_q;
    assign force_spike_neuron_select = sel_q;
    assign force_spike_en            = en_q;
    assign spike_valid               = valid_q;
    assign spike_data                = data_q;
endmodule

// File: tb/tb_snn_step_sequencer.sv
// Randomized self-checking bench for snn_step_sequencer.
// Expected behaviour comes from a step-timeline model of the run.
module tb_snn_step_sequencer;
    localparam int T  = 4;
    localparam int N  = 8;
    localparam int R  = 2;
    localparam int S  = 2;
    localparam int SW = 16;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, start, abort;
    logic [SW-1:0]       num_steps;
    logic                busy, done;
    logic [SW-1:0]       step_count;
    logic [T-1:0][N-1:0] spike_hist;
    logic [N-1:0]        blk_spike;
    logic [IW-1:0]       sel;
    logic                en, valid;
    logic [N-1:0]        data;

    logic                start6;
    logic [SW-1:0]       num6;
    logic                busy6, done6;
    logic [SW-1:0]       step6;
    logic [T-1:0][5:0]   hist6;
    logic [5:0]          blk6;
    logic [2:0]          sel6;
    logic                en6, valid6;
    logic [5:0]          data6;

    snn_step_sequencer_if #(.R(R), .N(N)) fif();
    snn_step_sequencer_if #(.R(R), .N(6)) fif6();

    snn_step_sequencer #(.T(T), .N(N), .R(R), .SETTLE(S), .SW(SW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_steps(num_steps), .busy(busy), .done(done),
        .step_count(step_count), .frc(fif), .spike_hist(spike_hist),
        .blk_spike(blk_spike), .force_spike_neuron_select(sel),
        .force_spike_en(en), .spike_valid(valid), .spike_data(data)
    );

    snn_step_sequencer #(.T(T), .N(6), .R(R), .SETTLE(S), .SW(SW)) u_dut6 (
        .clk(clk), .reset(reset), .start(start6), .abort(abort),
        .num_steps(num6), .busy(busy6), .done(done6),
        .step_count(step6), .frc(fif6), .spike_hist(hist6),
        .blk_spike(blk6), .force_spike_neuron_select(sel6),
        .force_spike_en(en6), .spike_valid(valid6), .spike_data(data6)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  hq[$];
    logic [R-1:0]  glog[$];
    logic [IW-1:0] slog[$];
    int exp_step = 0;
    int rr_last  = R - 1;
    int vcount, done_at;

    task automatic run_check(input int n, input int rmode, input bit cblk,
                             input logic [N-1:0] bval, input bit poke);
        int L;
        int c;
        logic [R-1:0] pr;
        logic [R-1:0][IW-1:0] pi;
        logic [N-1:0] pb;
        logic [R-1:0] eg;
        logic ee;
        logic [IW-1:0] es;
        logic [T-1:0][N-1:0] eh;
        bit inj, cap;
        L = n * (S + 2);
        ee = 1'b0;
        es = '0;
        vcount = 0;
        done_at = -1;
        if (cblk) blk_spike = bval;
        num_steps = SW'(n);
        start = 1'b1;
        for (int j = 0; j <= L + 2; j++) begin
            pr = fif.force_req;
            pi = fif.force_idx;
            pb = blk_spike;
            @(posedge clk); #1;
            if (j == 0) start = 1'b0;
            inj = (n > 0) && (j >= 1) && (j <= L) && ((j - 1) % (S + 2) == 0);
            cap = (n > 0) && (j >= 1) && (j <= L) && (j % (S + 2) == 0);
            if (j == 0 && n != 0) begin
                hq.delete();
                exp_step = 0;
            end
            eg = '0;
            if (inj) begin
                ee = 1'b0;
                for (int k = 1; k <= R; k++) begin
                    c = (rr_last + k) % R;
                    if (pr[c]) begin
                        eg[c] = 1'b1;
                        rr_last = c;
                        es = pi[c];
                        ee = 1'b1;
                        break;
                    end
                end
            end
            if (cap) begin
                hq.push_front(pb);
                if (hq.size() > T) void'(hq.pop_back());
                exp_step++;
                ee = 1'b0;
            end
            eh = '0;
            for (int k = 0; k < hq.size(); k++) eh[k] = hq[k];

            checks++;
            if (fif.force_gnt !== eg) begin
                errors++;
                $display("FAIL gnt j=%0d got %b exp %b", j, fif.force_gnt, eg);
            end
            checks++;
            if (en !== ee) begin
                errors++;
                $display("FAIL en j=%0d got %b exp %b", j, en, ee);
            end
            if (ee) begin
                checks++;
                if (sel !== es) begin
                    errors++;
                    $display("FAIL sel j=%0d got %0d exp %0d", j, sel, es);
                end
            end
            checks++;
            if (valid !== cap) begin
                errors++;
                $display("FAIL valid j=%0d got %b exp %b", j, valid, cap);
            end
            if (cap) begin
                checks++;
                if (data !== pb) begin
                    errors++;
                    $display("FAIL data j=%0d got %h exp %h", j, data, pb);
                end
            end
            checks++;
            if (done !== (j == L)) begin
                errors++;
                $display("FAIL done j=%0d got %b exp %b", j, done, j == L);
            end
            checks++;
            if (busy !== (j <= L)) begin
                errors++;
                $display("FAIL busy j=%0d got %b exp %b", j, busy, j <= L);
            end
            checks++;
            if (step_count !== SW'(exp_step)) begin
                errors++;
                $display("FAIL step j=%0d got %0d exp %0d", j, step_count, exp_step);
            end
            checks++;
            if (spike_hist !== eh) begin
                errors++;
                $display("FAIL hist j=%0d got %h exp %h", j, spike_hist, eh);
            end

            if (fif.force_gnt != '0) begin
                glog.push_back(fif.force_gnt);
                slog.push_back(sel);
            end
            if (valid) vcount++;
            if (done) done_at = j;

            if (!cblk) blk_spike = N'($urandom);
            if (rmode == 2) begin
                for (int r = 0; r < R; r++) begin
                    if (eg[r]) begin
                        fif.force_req[r] = 1'b0;
                    end else if (!fif.force_req[r] && $urandom_range(0, 3) == 0) begin
                        fif.force_req[r] = 1'b1;
                        fif.force_idx[r] = IW'($urandom);
                    end
                end
            end
            if (poke && n > 0) begin
                if (j == 1) begin
                    start = 1'b1;
                    num_steps = SW'($urandom_range(1, 9));
                end else if (j == 2) begin
                    start = 1'b0;
                end
            end
        end
        if (rmode == 1) fif.force_req = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_steps = '0;
        blk_spike = '0;
        fif.force_req = '0;
        fif.force_idx = '0;
        start6 = 1'b0;
        num6 = '0;
        blk6 = '0;
        fif6.force_req = '0;
        fif6.force_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, fif.force_gnt, en, valid} !== '0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0", {busy, done, fif.force_gnt, en, valid});
        end
        checks++;
        if (step_count !== '0 || spike_hist !== '0) begin
            errors++;
            $display("FAIL reset_state step %0d hist %h exp 0", step_count, spike_hist);
        end
        checks++;
        if (sel !== '0 || data !== '0) begin
            errors++;
            $display("FAIL reset_data sel %0d data %h exp 0", sel, data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        fif.force_req = '0;
        run_check(3, 0, 1'b1, 8'h05, 1'b0);
        checks++;
        if (vcount !== 3) begin
            errors++;
            $display("FAIL basic_valid_count got %0d exp 3", vcount);
        end
        checks++;
        if (done_at !== 12) begin
            errors++;
            $display("FAIL basic_done_at got %0d exp 12", done_at);
        end
        checks++;
        if (spike_hist !== {8'h00, 8'h05, 8'h05, 8'h05}) begin
            errors++;
            $display("FAIL basic_hist got %h exp 00050505", spike_hist);
        end
        checks++;
        if (step_count !== 16'd3) begin
            errors++;
            $display("FAIL basic_step got %0d exp 3", step_count);
        end
    endtask

    task automatic test_zero_steps;
        run_check(0, 0, 1'b1, 8'h33, 1'b0);
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("FAIL zero_valid got %0d exp 0", vcount);
        end
        checks++;
        if (done_at !== 0) begin
            errors++;
            $display("FAIL zero_done_at got %0d exp 0", done_at);
        end
    endtask

    task automatic test_round_robin;
        glog.delete();
        slog.delete();
        fif.force_idx = {3'd6, 3'd3};
        fif.force_req = 2'b11;
        run_check(4, 1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (glog.size() !== 4) begin
            errors++;
            $display("FAIL rr_count got %0d exp 4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (glog[i] !== ((i % 2) ? 2'b10 : 2'b01) ||
                    slog[i] !== ((i % 2) ? 3'd6 : 3'd3)) begin
                    errors++;
                    $display("FAIL rr_seq i=%0d got %b/%0d", i, glog[i], slog[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            run_check($urandom_range(1, 5), 2, 1'b0, 8'h00, r[0]);
        end
        fif.force_req = '0;
    endtask

    task automatic test_idle_controls;
        num_steps = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle busy got %b exp 0", busy);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || step_count !== SW'(exp_step)) begin
            errors++;
            $display("FAIL abort_idle busy %b step %0d exp 0/%0d", busy, step_count, exp_step);
        end
    endtask

    task automatic test_abort;
        fif.force_req = '0;
        blk_spike = 8'hA5;
        num_steps = 16'd3;
        start = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            @(posedge clk); #1;
            if (j == 0) start = 1'b0;
            if (j == 6) abort = 1'b1;
            if (j == 7) begin
                abort = 1'b0;
                checks++;
                if ({busy, done, en, valid} !== 4'b0000) begin
                    errors++;
                    $display("FAIL abort_ctl got %b exp 0000", {busy, done, en, valid});
                end
                checks++;
                if (step_count !== 16'd1) begin
                    errors++;
                    $display("FAIL abort_step got %0d exp 1", step_count);
                end
                checks++;
                if (spike_hist !== {8'h00, 8'h00, 8'h00, 8'hA5}) begin
                    errors++;
                    $display("FAIL abort_hist got %h exp 000000a5", spike_hist);
                end
            end
            if (j > 7) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_after j=%0d done %b busy %b exp 0", j, done, busy);
                end
            end
        end
        hq.delete();
        hq.push_back(8'hA5);
        exp_step = 1;
        run_check(2, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_midrun;
        fif.force_idx = {3'd2, 3'd5};
        fif.force_req = 2'b01;
        num_steps = 16'd3;
        start = 1'b1;
        for (int j = 0; j <= 3; j++) begin
            @(posedge clk); #1;
            if (j == 0) start = 1'b0;
            if (j == 1) begin
                checks++;
                if (fif.force_gnt !== 2'b01) begin
                    errors++;
                    $display("FAIL pre_reset_gnt got %b exp 01", fif.force_gnt);
                end
                fif.force_req = '0;
            end
            if (j == 2) reset = 1'b0;
            if (j == 3) begin
                reset = 1'b1;
                checks++;
                if ({busy, done, fif.force_gnt, en, valid, sel} !== '0 ||
                    step_count !== '0 || spike_hist !== '0 || data !== '0) begin
                    errors++;
                    $display("FAIL midrun_reset busy %b en %b step %0d hist %h exp 0",
                             busy, en, step_count, spike_hist);
                end
            end
        end
        hq.delete();
        exp_step = 0;
        rr_last = R - 1;
        glog.delete();
        slog.delete();
        fif.force_idx = {3'd6, 3'd3};
        fif.force_req = 2'b11;
        run_check(2, 1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (glog.size() == 0 || glog[0] !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_first_gnt got %b exp 01",
                     (glog.size() == 0) ? 2'b00 : glog[0]);
        end
    endtask

    task automatic test_invalid_target;
        int gcnt, ecnt, vcnt, dat;
        gcnt = 0;
        ecnt = 0;
        vcnt = 0;
        dat = -1;
        fif6.force_idx = {3'd7, 3'd6};
        fif6.force_req = 2'b11;
        num6 = 16'd2;
        start6 = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            @(posedge clk); #1;
            if (j == 0) start6 = 1'b0;
            if (fif6.force_gnt != '0) gcnt++;
            if (en6) ecnt++;
            if (valid6) vcnt++;
            if (done6) dat = j;
            if (j == 1 || j == 5) begin
                checks++;
                if (fif6.force_gnt !== ((j == 1) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL inv_gnt j=%0d got %b", j, fif6.force_gnt);
                end
            end
        end
        fif6.force_req = '0;
        checks++;
        if (gcnt !== 2 || ecnt !== 0) begin
            errors++;
            $display("FAIL inv_target gnts %0d en_cycles %0d exp 2/0", gcnt, ecnt);
        end
        checks++;
        if (dat !== 8 || step6 !== 16'd2 || vcnt !== 2 || busy6 !== 1'b0) begin
            errors++;
            $display("FAIL inv_complete done_at %0d step %0d valid %0d exp 8/2/2", dat, step6, vcnt);
        end
        checks++;
        if (hist6 !== '0 || data6 !== '0) begin
            errors++;
            $display("FAIL inv_hist got %h/%h exp 0", hist6, data6);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_steps();
        test_round_robin();
        test_random();
        test_idle_controls();
        test_abort();
        test_reset_midrun();
        test_invalid_target();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
